toggle_hs_rx: RTL
=================

# toggle_hs_rx

Receive end of the two-phase (toggle) handshake driven by the toggle flip-flop sender logic. Each transition of `req_t` marks one new word on `data_in`. The block captures the word into a small FIFO and answers by toggling `ack_t`, T-FF style. Stored words go to the downstream consumer over a valid/ready interface; when the FIFO is full, `ack_t` is withheld, which back-pressures the sender.

## Interface
- `DATA_W`, default 8: word width.
- `DEPTH`, default 4: FIFO depth; power of two, at least 2.
- `clk` input, 1: the single clock; all state updates on its rising edge.
- `reset` input, 1: asynchronous, active-low reset. Asserted at 0 and applied immediately. Release is synchronous to `clk`.
- `req_t` input, 1: request toggle; every level change (0→1 or 1→0) is one request.
- `data_in` input, `DATA_W`: word. The sender holds it stable from the `req_t` toggle until `ack_t` toggles.
- `ack_t` output, 1: acknowledge toggle; changes level once per accepted word.
- `out_data` output, `DATA_W`: head of the FIFO.
- `out_valid` output, 1: FIFO non-empty.
- `out_ready` input, 1: consumer accepts `out_data` when `out_valid` and `out_ready` are both 1 at an edge.
- `count` output, clog2(`DEPTH`)+1: number of stored words, 0..`DEPTH`.

## Operation
- Internal state:
  - `req_last`: copy of the last accepted request phase.
  - Read and write pointers, each clog2(`DEPTH`) bits, wrapping modulo `DEPTH`.
  - `count` register.
  - Storage array.
- Request seen: `req_s != req_last`. `req_s` is `req_t` directly, or the synchronized copy (see Configuration).
- Push, when the request is seen and `count < DEPTH` at the edge:
  - `mem[wr_ptr] <= data_in`, then `wr_ptr` increments.
  - `req_last <= req_s`.
  - `ack_t <= ~ack_t`.
- Request while full: no push and no `ack_t` change. The request stays pending because `req_last` is unchanged. It is accepted on the first edge where `count < DEPTH`.
- Pop, when `out_valid && out_ready`: `rd_ptr` increments.
- `count` update rules:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
- Full and popping in the same cycle: pop only. The pending push lands on the next edge, because fullness is judged on the registered `count`.
- Empty: no fall-through. A word written at edge N gives `out_valid = 1` after edge N.
- `out_valid = (count != 0)`; `out_data = mem[rd_ptr]`. Both outputs are combinational from registers.
- `out_ready` while empty: ignored; pointers and `count` are unchanged.
- At most one push per edge. A sender that toggles `req_t` twice before `ack_t` toggles breaks the protocol; only the net phase is seen.
- Reset (any time, including mid-transfer):
  - Cleared to 0: `ack_t`, `req_last`, pointers, `count`, storage, sync flops.
  - Resulting outputs: `out_valid = 0`, `out_data = 0`, `count = 0`.
  - A pending request is lost. If `req_t = 1` at reset release, it reads as a new request.

## Timing
- Without sync: request-to-`ack_t` latency is 1 edge. `req_t` toggles before edge N; `ack_t` toggles after edge N, provided the FIFO is not full.
- With sync: latency is 3 edges. Two edges pass through the synchronizer, and the push happens on the third. `data_in` is sampled on the push edge.
- Push-to-`out_valid`: 1 edge.
- Sustained rate: one word per request/ack round trip. The sender toggles `req_t` again only after it sees `ack_t` change.

## Configuration
- `TOGGLE_RX_SYNC_EN` defined: `req_t` passes through a two-flop synchronizer (both flops reset to 0) before edge detection. This is for a sender in an unrelated clock domain. Latency is as given in Timing.
- `TOGGLE_RX_SYNC_EN` undefined: `req_t` is used directly. The sender must be synchronous to `clk`.

## Test plan
- Reset with `req_t = 0` → `ack_t = 0`, `count = 0`, `out_valid = 0`. Then assert `reset = 0` mid-transfer → all outputs return to 0 immediately, without waiting for a clock edge.
- Single word, no sync: toggle `req_t` 0→1 with `data_in = 8'hA5` → `ack_t` goes 1 after the next edge. `out_valid = 1`, `out_data = 8'hA5` one edge later. `out_ready = 1` → `count` returns to 0.
- Fill: four handshakes `8'h01`..`8'h04` with `out_ready = 0` → `count = 4`. A fifth toggle (`8'h05`) leaves `ack_t` unchanged for 10 cycles.
- Release backpressure: from the full state with the fifth request pending, pulse `out_ready` for one cycle → pop `8'h01`. On the next edge, `8'h05` is pushed and `ack_t` toggles. Drain order is `8'h02`, `8'h03`, `8'h04`, `8'h05`.
- Wrap-around: run 10 back-to-back words `8'h10`..`8'h19` with `out_ready` held 1 → all are received in order, `count` never exceeds 1, pointers wrap twice.
- With `TOGGLE_RX_SYNC_EN` defined: a single toggle gives `ack_t` changing exactly 3 edges after the `req_t` change, and the data is correct.

Source files
------------

// File: rtl/toggle_hs_rx.sv
// Receive side of a two-phase (toggle) handshake: each req_t edge pushes data_in into a FIFO, answered by an ack_t toggle.
// Define TOGGLE_RX_SYNC_EN to pass req_t through a two-flop synchronizer for a sender in another clock domain.
module toggle_hs_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_t,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ack_t,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic              req_s;
  logic              req_last;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;
  logic              pop;

`ifdef TOGGLE_RX_SYNC_EN
  logic req_p0;
  logic req_p1;

  // Synchronizer stages: req_t -> req_p0 -> req_p1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_p0 <= 1'b0;
      req_p1 <= 1'b0;
    end else begin
      req_p0 <= req_t;
      req_p1 <= req_p0;
    end
  end

  assign req_s = req_p1;
`else
  assign req_s = req_t;
`endif

  // Fullness is judged on the registered count, so a pop frees space only for the next edge.
  assign push = (req_s != req_last) && (count < FULL);
  assign pop  = out_valid && out_ready;

  // Handshake and pointer state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_last <= 1'b0;
      ack_t    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        req_last <= req_s;
        ack_t    <= ~ack_t;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is cleared too so out_data reads zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule
